// File: rtl/ps2_host_cmd_ctrl_if.sv
// PS/2 host command sequencer bus bundle.
// Groups the register-side command handshake, transmitter handshake,
// receive-decoder input, scan-code pass-through and response outputs.
// The master modport is the sequencer's view; slave is the peer side
// (register interface, transmitter, decoder, scan-code path).
interface ps2_host_cmd_ctrl_if;
    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       cmd_has_arg;
    logic [7:0] cmd_arg;
    logic       cmd_ready;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx_busy;
    logic       tx_done;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       pass_valid;
    logic [7:0] pass_byte;
    logic       rsp_valid;
    logic [1:0] rsp_status;
    logic       busy;

    modport master (
        input  cmd_valid, cmd_byte, cmd_has_arg, cmd_arg,
        input  tx_busy, tx_done, rx_valid, rx_byte,
        output cmd_ready, tx_start, tx_byte,
        output pass_valid, pass_byte, rsp_valid, rsp_status, busy
    );

    modport slave (
        output cmd_valid, cmd_byte, cmd_has_arg, cmd_arg,
        output tx_busy, tx_done, rx_valid, rx_byte,
        input  cmd_ready, tx_start, tx_byte,
        input  pass_valid, pass_byte, rsp_valid, rsp_status, busy
    );
endinterface

// File: rtl/ps2_host_cmd_ctrl.sv
// PS/2 host-to-device command sequencer.
// Sends a command byte (and optional argument byte) through the PS/2
// transmitter, consumes the device ACK/RESEND/ERROR responses, retries on
// RESEND, times out stalled phases and forwards every other received byte
// to the scan-code path.
// Optional build macro PS2_BAT_WAIT_EN: after the ACK of a 0xFF reset
// command, wait for the BAT completion byte 0xAA before reporting done.
module ps2_host_cmd_ctrl #(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int MAX_RETRY      = 3,
    parameter int TMR_W          = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    ps2_host_cmd_ctrl_if.master  bus
);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_RESEND = 8'hFE;
    localparam logic [7:0] RSP_ERROR  = 8'hFC;
    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] BAT_OK     = 8'hAA;

    typedef enum logic [2:0] {
        IDLE,
        SEND_CMD,
        WAIT_ACK_CMD,
        SEND_ARG,
        WAIT_ACK_ARG,
        DONE,
        ERR
`ifdef PS2_BAT_WAIT_EN
        , WAIT_BAT
`endif
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic [RW-1:0]    retry_cnt;
    logic             sent;
    logic [7:0]       cmd_q;
    logic [7:0]       arg_q;
    logic             has_arg_q;
    logic             consume;

    logic             tx_start_q;
    logic [7:0]       tx_byte_q;
    logic             pass_valid_q;
    logic [7:0]       pass_byte_q;
    logic             rsp_valid_q;
    logic [1:0]       rsp_status_q;

    assign bus.cmd_ready  = (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.tx_start   = tx_start_q;
    assign bus.tx_byte    = tx_byte_q;
    assign bus.pass_valid = pass_valid_q;
    assign bus.pass_byte  = pass_byte_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_status = rsp_status_q;

    // Decide whether the byte now on the decoder is a response meant for us.
    always_comb begin
        consume = 1'b0;
        if (bus.rx_valid && (state == WAIT_ACK_CMD || state == WAIT_ACK_ARG))
            consume = (bus.rx_byte == RSP_ACK) || (bus.rx_byte == RSP_RESEND) ||
                      (bus.rx_byte == RSP_ERROR);
`ifdef PS2_BAT_WAIT_EN
        if (bus.rx_valid && state == WAIT_BAT)
            consume = (bus.rx_byte == BAT_OK) || (bus.rx_byte == RSP_ERROR);
`endif
    end

    // Command sequencer FSM with registered transmitter, pass-through and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            retry_cnt    <= '0;
            sent         <= 1'b0;
            cmd_q        <= '0;
            arg_q        <= '0;
            has_arg_q    <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_byte_q    <= '0;
            pass_valid_q <= 1'b0;
            pass_byte_q  <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= 2'b00;
        end else begin
            tx_start_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            pass_valid_q <= bus.rx_valid && !consume;
            if (bus.rx_valid && !consume)
                pass_byte_q <= bus.rx_byte;

            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        cmd_q     <= bus.cmd_byte;
                        arg_q     <= bus.cmd_arg;
                        has_arg_q <= bus.cmd_has_arg;
                        retry_cnt <= '0;
                        sent      <= 1'b0;
                        timer     <= '0;
                        state     <= SEND_CMD;
                    end
                end

                SEND_CMD, SEND_ARG: begin
                    timer <= timer + TMR_W'(1);
                    if (sent && bus.tx_done) begin
                        timer <= '0;
                        state <= (state == SEND_CMD) ? WAIT_ACK_CMD : WAIT_ACK_ARG;
                    end else if (timer == TMR_LAST) begin
                        timer        <= '0;
                        state        <= ERR;
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= 2'b10;
                    end else if (!sent && !bus.tx_busy) begin
                        sent       <= 1'b1;
                        tx_start_q <= 1'b1;
                        tx_byte_q  <= (state == SEND_CMD) ? cmd_q : arg_q;
                    end
                end

                WAIT_ACK_CMD, WAIT_ACK_ARG: begin
                    timer <= timer + TMR_W'(1);
                    if (consume && bus.rx_byte == RSP_ACK) begin
                        timer <= '0;
                        if (state == WAIT_ACK_CMD && has_arg_q) begin
                            sent  <= 1'b0;
                            state <= SEND_ARG;
`ifdef PS2_BAT_WAIT_EN
                        end else if (state == WAIT_ACK_CMD && cmd_q == CMD_RESET) begin
                            state <= WAIT_BAT;
`endif
                        end else begin
                            state        <= DONE;
                            rsp_valid_q  <= 1'b1;
                            rsp_status_q <= 2'b00;
                        end
                    end else if (consume && bus.rx_byte == RSP_RESEND) begin
                        timer     <= '0;
                        retry_cnt <= retry_cnt + RW'(1);
                        if (retry_cnt == RW'(MAX_RETRY)) begin
                            state        <= ERR;
                            rsp_valid_q  <= 1'b1;
                            rsp_status_q <= 2'b01;
                        end else begin
                            sent  <= 1'b0;
                            state <= (state == WAIT_ACK_CMD) ? SEND_CMD : SEND_ARG;
                        end
                    end else if (consume) begin
                        timer        <= '0;
                        state        <= ERR;
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= 2'b11;
                    end else if (timer == TMR_LAST) begin
                        timer        <= '0;
                        state        <= ERR;
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= 2'b10;
                    end
                end

`ifdef PS2_BAT_WAIT_EN
                WAIT_BAT: begin
                    timer <= timer + TMR_W'(1);
                    if (consume && bus.rx_byte == BAT_OK) begin
                        timer        <= '0;
                        state        <= DONE;
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= 2'b00;
                    end else if (consume) begin
                        timer        <= '0;
                        state        <= ERR;
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= 2'b11;
                    end else if (timer == TMR_LAST) begin
                        timer        <= '0;
                        state        <= ERR;
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= 2'b10;
                    end
                end
`endif

                DONE, ERR: begin
                    timer <= '0;
                    state <= IDLE;
                end

                default: begin
                    timer <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_host_cmd_ctrl.sv
// Directed testbench for ps2_host_cmd_ctrl (TIMEOUT_CYCLES = 50).
// Honors PS2_BAT_WAIT_EN to pick the expected reset-command behaviour.
module tb_ps2_host_cmd_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    int         tx_cnt   = 0;
    int         pass_cnt = 0;
    int         rsp_cnt  = 0;
    logic [7:0] tx_log[$];

    ps2_host_cmd_ctrl_if bus ();

    ps2_host_cmd_ctrl #(
        .TIMEOUT_CYCLES(50),
        .MAX_RETRY     (3),
        .TMR_W         (18)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Record transmitter starts, pass-through bytes and responses on the falling edge.
    always @(negedge clk) begin
        if (bus.tx_start) begin
            tx_cnt = tx_cnt + 1;
            tx_log.push_back(bus.tx_byte);
        end
        if (bus.pass_valid)
            pass_cnt = pass_cnt + 1;
        if (bus.rsp_valid)
            rsp_cnt = rsp_cnt + 1;
    end

    // Absolute runtime bound.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, required finish before 200us");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic issue_cmd(input logic [7:0] b, input logic has, input logic [7:0] a);
        bus.cmd_valid   = 1'b1;
        bus.cmd_byte    = b;
        bus.cmd_has_arg = has;
        bus.cmd_arg     = a;
        tick();
        bus.cmd_valid   = 1'b0;
    endtask

    task automatic wait_tx(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.tx_start) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic pulse_done();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_start: got %b required 0", bus.tx_start); end
        checks++; if (bus.tx_byte !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_byte: got %h required 00", bus.tx_byte); end
        checks++; if (bus.pass_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_pass_valid: got %b required 0", bus.pass_valid); end
        checks++; if (bus.pass_byte !== 8'h00) begin errors++; $display("[TB] FAIL reset_pass_byte: got %h required 00", bus.pass_byte); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b required 0", bus.rsp_valid); end
        checks++; if (bus.rsp_status !== 2'b00) begin errors++; $display("[TB] FAIL reset_rsp_status: got %b required 00", bus.rsp_status); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b required 0", bus.busy); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready: got %b required 1", bus.cmd_ready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_simple_cmd();
        int t0 = tx_cnt;
        int p0 = pass_cnt;
        bit ok;
        issue_cmd(8'hF4, 1'b0, 8'h00);
        wait_tx(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL simple_tx_start: got none required pulse within 20 cycles"); end
        checks++; if (bus.tx_byte !== 8'hF4) begin errors++; $display("[TB] FAIL simple_tx_byte: got %h required F4", bus.tx_byte); end
        pulse_done();
        send_rx(8'hFA);
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL simple_rsp_valid: got %b required 1", bus.rsp_valid); end
        checks++; if (bus.rsp_status !== 2'b00) begin errors++; $display("[TB] FAIL simple_rsp_status: got %b required 00", bus.rsp_status); end
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL simple_ready_during_rsp: got %b required 0", bus.cmd_ready); end
        tick();
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL simple_ready_after: got %b required 1", bus.cmd_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL simple_rsp_one_cycle: got %b required 0", bus.rsp_valid); end
        checks++; if (tx_cnt - t0 !== 1) begin errors++; $display("[TB] FAIL simple_tx_count: got %0d required 1", tx_cnt - t0); end
        checks++; if (pass_cnt - p0 !== 0) begin errors++; $display("[TB] FAIL simple_no_pass: got %0d required 0", pass_cnt - p0); end
    endtask

    task automatic test_cmd_with_arg();
        int t0 = tx_cnt;
        bit ok1, ok2;
        issue_cmd(8'hED, 1'b1, 8'h07);
        wait_tx(ok1);
        pulse_done();
        send_rx(8'hFA);
        wait_tx(ok2);
        pulse_done();
        send_rx(8'hFA);
        checks++; if (!(ok1 && ok2)) begin errors++; $display("[TB] FAIL arg_tx_start: got %b%b required 11", ok1, ok2); end
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_status !== 2'b00) begin errors++; $display("[TB] FAIL arg_rsp: got valid %b status %b required 1/00", bus.rsp_valid, bus.rsp_status); end
        tick();
        checks++; if (tx_cnt - t0 !== 2) begin errors++; $display("[TB] FAIL arg_tx_count: got %0d required 2", tx_cnt - t0); end
        checks++; if (tx_log[t0] !== 8'hED || tx_log[t0+1] !== 8'h07) begin errors++; $display("[TB] FAIL arg_tx_sequence: got %h %h required ED 07", tx_log[t0], tx_log[t0+1]); end
    endtask

    task automatic test_resend_exhausted();
        int t0 = tx_cnt;
        int r0 = rsp_cnt;
        int twos = 0;
        int early = 0;
        bit ok;
        bit all_ok = 1'b1;
        issue_cmd(8'hED, 1'b1, 8'h02);
        wait_tx(ok);
        all_ok &= ok;
        pulse_done();
        send_rx(8'hFA);
        for (int i = 0; i < 4; i++) begin
            wait_tx(ok);
            all_ok &= ok;
            pulse_done();
            send_rx(8'hFE);
            if (i < 3 && bus.rsp_valid) early++;
        end
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_status !== 2'b01) begin errors++; $display("[TB] FAIL resend_rsp: got valid %b status %b required 1/01", bus.rsp_valid, bus.rsp_status); end
        tick();
        for (int i = t0; i < tx_cnt; i++)
            if (tx_log[i] == 8'h02) twos++;
        checks++; if (!all_ok || early != 0) begin errors++; $display("[TB] FAIL resend_flow: got tx_ok %b early_rsp %0d required 1 and 0", all_ok, early); end
        checks++; if (twos != 4) begin errors++; $display("[TB] FAIL resend_arg_count: got %0d required 4", twos); end
        checks++; if (tx_cnt - t0 !== 5) begin errors++; $display("[TB] FAIL resend_tx_total: got %0d required 5", tx_cnt - t0); end
        checks++; if (rsp_cnt - r0 !== 1) begin errors++; $display("[TB] FAIL resend_rsp_count: got %0d required 1", rsp_cnt - r0); end
    endtask

    task automatic test_passthrough();
        int p0 = pass_cnt;
        bit ok;
        issue_cmd(8'hF4, 1'b0, 8'h00);
        wait_tx(ok);
        pulse_done();
        send_rx(8'h1C);
        checks++; if (bus.pass_valid !== 1'b1 || bus.pass_byte !== 8'h1C) begin errors++; $display("[TB] FAIL pass_byte: got valid %b byte %h required 1/1C", bus.pass_valid, bus.pass_byte); end
        checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL pass_stay_wait: got rsp %b busy %b required 0/1", bus.rsp_valid, bus.busy); end
        send_rx(8'hFA);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_status !== 2'b00) begin errors++; $display("[TB] FAIL pass_rsp: got valid %b status %b required 1/00", bus.rsp_valid, bus.rsp_status); end
        tick();
        checks++; if (pass_cnt - p0 !== 1) begin errors++; $display("[TB] FAIL pass_count: got %0d required 1", pass_cnt - p0); end
    endtask

    task automatic test_device_error();
        bit ok;
        issue_cmd(8'hF4, 1'b0, 8'h00);
        wait_tx(ok);
        pulse_done();
        send_rx(8'hFC);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_status !== 2'b11) begin errors++; $display("[TB] FAIL error_rsp: got valid %b status %b required 1/11", bus.rsp_valid, bus.rsp_status); end
        tick();
    endtask

    task automatic test_timeout();
        int n = 0;
        int r1;
        bit ok;
        issue_cmd(8'hF4, 1'b0, 8'h00);
        wait_tx(ok);
        pulse_done();
        while (!bus.rsp_valid && n < 200) begin
            tick();
            n++;
        end
        checks++; if (n != 50) begin errors++; $display("[TB] FAIL timeout_latency: got %0d cycles required 50", n); end
        checks++; if (bus.rsp_status !== 2'b10) begin errors++; $display("[TB] FAIL timeout_status: got %b required 10", bus.rsp_status); end
        tick();
        r1 = rsp_cnt;
        issue_cmd(8'hF4, 1'b0, 8'h00);
        wait_tx(ok);
        pulse_done();
        repeat (10) tick();
        rst = 1'b1;
        tick();
        checks++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_idle: got ready %b busy %b rsp %b required 1/0/0", bus.cmd_ready, bus.busy, bus.rsp_valid); end
        rst = 1'b0;
        repeat (60) tick();
        checks++; if (rsp_cnt !== r1) begin errors++; $display("[TB] FAIL midreset_no_rsp: got %0d required %0d", rsp_cnt, r1); end
    endtask

    task automatic test_back_to_back();
        int t0 = tx_cnt;
        bit ok;
        bus.tx_busy = 1'b1;
        issue_cmd(8'hF4, 1'b0, 8'h00);
        repeat (4) tick();
        checks++; if (tx_cnt - t0 !== 0) begin errors++; $display("[TB] FAIL busy_holdoff: got %0d starts required 0", tx_cnt - t0); end
        bus.tx_busy = 1'b0;
        wait_tx(ok);
        bus.tx_done  = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_byte  = 8'h55;
        tick();
        bus.tx_done  = 1'b0;
        bus.rx_valid = 1'b0;
        checks++; if (bus.pass_valid !== 1'b1 || bus.pass_byte !== 8'h55) begin errors++; $display("[TB] FAIL simul_pass: got valid %b byte %h required 1/55", bus.pass_valid, bus.pass_byte); end
        bus.cmd_valid = 1'b1;
        bus.cmd_byte  = 8'h12;
        repeat (3) tick();
        bus.cmd_valid = 1'b0;
        send_rx(8'hFA);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_status !== 2'b00) begin errors++; $display("[TB] FAIL simul_advance_rsp: got valid %b status %b required 1/00", bus.rsp_valid, bus.rsp_status); end
        tick();
        checks++; if (!ok || tx_cnt - t0 !== 1) begin errors++; $display("[TB] FAIL ignore_cmd_valid: got %0d starts required 1", tx_cnt - t0); end
    endtask

    task automatic test_bat();
        int p0 = pass_cnt;
        bit ok;
        issue_cmd(8'hFF, 1'b0, 8'h00);
        wait_tx(ok);
        pulse_done();
        send_rx(8'hFA);
`ifdef PS2_BAT_WAIT_EN
        checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL bat_wait: got rsp %b busy %b required 0/1", bus.rsp_valid, bus.busy); end
        repeat (3) tick();
        send_rx(8'hAA);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_status !== 2'b00) begin errors++; $display("[TB] FAIL bat_done: got valid %b status %b required 1/00", bus.rsp_valid, bus.rsp_status); end
        tick();
        checks++; if (pass_cnt - p0 !== 0) begin errors++; $display("[TB] FAIL bat_consumed: got %0d passes required 0", pass_cnt - p0); end
`else
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_status !== 2'b00) begin errors++; $display("[TB] FAIL reset_cmd_done: got valid %b status %b required 1/00", bus.rsp_valid, bus.rsp_status); end
        tick();
        send_rx(8'hAA);
        checks++; if (bus.pass_valid !== 1'b1 || bus.pass_byte !== 8'hAA) begin errors++; $display("[TB] FAIL bat_passthrough: got valid %b byte %h required 1/AA", bus.pass_valid, bus.pass_byte); end
        checks++; if (pass_cnt - p0 !== 1) begin errors++; $display("[TB] FAIL bat_pass_count: got %0d required 1", pass_cnt - p0); end
`endif
    endtask

    initial begin
        rst             = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_byte    = 8'h00;
        bus.cmd_has_arg = 1'b0;
        bus.cmd_arg     = 8'h00;
        bus.tx_busy     = 1'b0;
        bus.tx_done     = 1'b0;
        bus.rx_valid    = 1'b0;
        bus.rx_byte     = 8'h00;
        $display("[TB] starting ps2_host_cmd_ctrl bench");
        test_reset();
        test_simple_cmd();
        test_cmd_with_arg();
        test_resend_exhausted();
        test_passthrough();
        test_device_error();
        test_timeout();
        test_back_to_back();
        test_bat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
